// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-master RAM arbiter: FSM encoding and port ids.
package mem_arbiter_pkg;

    // 2'd3 is unused; the FSM treats it as illegal and falls back to StIdle.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StServe = 2'd1,
        StAck   = 2'd2
    } state_e;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational 2-way round-robin picker: a lone request wins outright,
// a tie goes to the port that did not win last time.
module rr_arbiter2
    import mem_arbiter_pkg::*;
(
    input  logic req_i,
    input  logic req_d,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    // Pick the winner among the pending requests.
    always_comb begin
        grant_valid = req_i | req_d;
        grant_id    = PORT_I;
        if (req_i && req_d) begin
            grant_id = ~last_grant;
        end else if (req_d) begin
            grant_id = PORT_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a single-port asynchronous-read RAM.
// Fetch (I, read-only) and load/store (D) masters are serialised through an
// IDLE -> SERVE -> ACK sequence; every output, including read data, is registered.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned addrSize = 16,
    parameter int unsigned wordSize = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [addrSize-1:0] i_addr,
    output logic [wordSize-1:0] i_rdata,
    output logic                i_ack,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [addrSize-1:0] d_addr,
    input  logic [wordSize-1:0] d_wdata,
    output logic [wordSize-1:0] d_rdata,
    output logic                d_ack,
    output logic [addrSize-1:0] ram_addr,
    output logic [wordSize-1:0] ram_wdata,
    output logic                ram_we,
    input  logic [wordSize-1:0] ram_rdata,
    output logic                busy
);

    state_e              r_state;
    state_e              w_state_nxt;
    // Port that won the most recent arbitration; also identifies the port
    // being served while a transaction is in flight.
    logic                r_last_grant;
    logic                w_last_grant_nxt;
    logic [addrSize-1:0] r_ram_addr;
    logic [addrSize-1:0] w_ram_addr_nxt;
    logic [wordSize-1:0] r_ram_wdata;
    logic [wordSize-1:0] w_ram_wdata_nxt;
    logic                r_ram_we;
    logic                w_ram_we_nxt;
    logic                r_i_ack;
    logic                w_i_ack_nxt;
    logic                r_d_ack;
    logic                w_d_ack_nxt;
    logic [wordSize-1:0] r_i_rdata;
    logic [wordSize-1:0] w_i_rdata_nxt;
    logic [wordSize-1:0] r_d_rdata;
    logic [wordSize-1:0] w_d_rdata_nxt;
    logic                r_busy;
    logic                w_busy_nxt;

    logic                w_grant_valid;
    logic                w_grant_id;

    rr_arbiter2 u_rr_arbiter2 (
        .req_i       (i_req),
        .req_d       (d_req),
        .last_grant  (r_last_grant),
        .grant_valid (w_grant_valid),
        .grant_id    (w_grant_id)
    );

    // Next-state and next-output logic for the three-cycle transaction.
    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        w_ram_addr_nxt   = r_ram_addr;
        w_ram_wdata_nxt  = r_ram_wdata;
        w_ram_we_nxt     = 1'b0;
        w_i_ack_nxt      = 1'b0;
        w_d_ack_nxt      = 1'b0;
        w_i_rdata_nxt    = r_i_rdata;
        w_d_rdata_nxt    = r_d_rdata;

        case (r_state)
            StIdle: begin
                if (w_grant_valid) begin
                    w_last_grant_nxt = w_grant_id;
                    if (w_grant_id == PORT_D) begin
                        w_ram_addr_nxt  = d_addr;
                        w_ram_wdata_nxt = d_wdata;
                        w_ram_we_nxt    = d_we;
                    end else begin
                        w_ram_addr_nxt  = i_addr;
                        w_ram_wdata_nxt = '0;
                        w_ram_we_nxt    = 1'b0;
                    end
                    w_state_nxt = StServe;
                end
            end
            StServe: begin
                // RAM read path is asynchronous; capture it at the edge ending SERVE.
                if (r_last_grant == PORT_D) begin
                    if (!r_ram_we) begin
                        w_d_rdata_nxt = ram_rdata;
                    end
                    w_d_ack_nxt = 1'b1;
                end else begin
                    w_i_rdata_nxt = ram_rdata;
                    w_i_ack_nxt   = 1'b1;
                end
                w_state_nxt = StAck;
            end
            StAck: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase

        w_busy_nxt = (w_state_nxt != StIdle);
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= StIdle;
            r_last_grant <= PORT_I;
            r_ram_addr   <= '0;
            r_ram_wdata  <= '0;
            r_ram_we     <= 1'b0;
            r_i_ack      <= 1'b0;
            r_d_ack      <= 1'b0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_ram_addr   <= w_ram_addr_nxt;
            r_ram_wdata  <= w_ram_wdata_nxt;
            r_ram_we     <= w_ram_we_nxt;
            r_i_ack      <= w_i_ack_nxt;
            r_d_ack      <= w_d_ack_nxt;
            r_i_rdata    <= w_i_rdata_nxt;
            r_d_rdata    <= w_d_rdata_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign ram_we    = r_ram_we;
    assign i_ack     = r_i_ack;
    assign d_ack     = r_d_ack;
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;
    assign busy      = r_busy;

endmodule
